// File: rtl/jk_pkg.sv
// Shared types for the JK bank driver: FSM states, {j,k} command encodings
// and the single-bit JK excitation function.
package jk_pkg;

  localparam int unsigned TRIES_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Encoded as {j,k}
  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_cmd_e;

  // Command that moves one flop from q to target in a single edge
  function automatic jk_cmd_e excite_bit(input logic q, input logic target, input logic toggle);
    jk_cmd_e cmd;
    if (q == target) begin
      cmd = HOLD;
    end else if (toggle) begin
      cmd = TOGGLE;
    end else if (target) begin
      cmd = SET;
    end else begin
      cmd = RESET;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/jk_bank_driver_if.sv
// Request/response handshake between a sequencer (master) and jk_bank_driver (slave).
interface jk_bank_driver_if
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
);

  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_target;
  logic               req_toggle;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_ok;
  logic [TRIES_W-1:0] resp_tries;
  logic [ERR_W-1:0]   err_count;

  modport master (
    output req_valid, req_target, req_toggle, resp_ready,
    input  req_ready, resp_valid, resp_ok, resp_tries, err_count
  );

  modport slave (
    input  req_valid, req_target, req_toggle, resp_ready,
    output req_ready, resp_valid, resp_ok, resp_tries, err_count
  );

endinterface

// File: rtl/jk_excite.sv
// WIDTH-wide JK excitation: j/k values that take each flop from q to target.
module jk_excite
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] target,
  input  logic             toggle,
  output logic [WIDTH-1:0] j_next,
  output logic [WIDTH-1:0] k_next
);

  logic [1:0] cmd;

  always_comb begin
    j_next = '0;
    k_next = '0;
    cmd    = HOLD;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cmd       = excite_bit(q[i], target[i], toggle);
      j_next[i] = cmd[1];
      k_next[i] = cmd[0];
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a JK flip-flop bank to a requested word, verifies it through q_fb,
// retries up to MAX_RETRY times and reports pass/fail with a try count.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned ERR_W     = 8
) (
  input  logic              clk,
  input  logic              clear_n,
  jk_bank_driver_if.slave   bus,
  input  logic [WIDTH-1:0]  q_fb,
  output logic [WIDTH-1:0]  j,
  output logic [WIDTH-1:0]  k
);

  localparam logic [TRIES_W-1:0] LAST_RETRY = TRIES_W'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   target_q, target_d;
  logic               toggle_q, toggle_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [WIDTH-1:0]   j_q, j_d, k_q, k_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_ok_q, resp_ok_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic [WIDTH-1:0]   exc_target;
  logic               exc_toggle;
  logic [WIDTH-1:0]   j_next, k_next;

  // In IDLE the excitation is computed from the incoming request, otherwise from the latched one
  assign exc_target = (state_q == IDLE) ? bus.req_target : target_q;
  assign exc_toggle = (state_q == IDLE) ? bus.req_toggle : toggle_q;

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .q      (q_fb),
    .target (exc_target),
    .toggle (exc_toggle),
    .j_next (j_next),
    .k_next (k_next)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    toggle_d     = toggle_q;
    tries_d      = tries_q;
    j_d          = '0;
    k_d          = '0;
    resp_valid_d = resp_valid_q;
    resp_ok_d    = resp_ok_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          target_d = bus.req_target;
          toggle_d = bus.req_toggle;
          tries_d  = TRIES_W'(1);
          j_d      = j_next;
          k_d      = k_next;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (q_fb == target_q) begin
          resp_ok_d    = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (tries_q <= LAST_RETRY) begin
          tries_d = tries_q + TRIES_W'(1);
          j_d     = j_next;
          k_d     = k_next;
          state_d = DRIVE;
        end else begin
          resp_ok_d    = 1'b0;
          resp_valid_d = 1'b1;
          if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      target_q     <= '0;
      toggle_q     <= 1'b0;
      tries_q      <= '0;
      j_q          <= '0;
      k_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      toggle_q     <= toggle_d;
      tries_q      <= tries_d;
      j_q          <= j_d;
      k_q          <= k_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_ok    = resp_ok_q;
  assign bus.resp_tries = tries_q;
  assign bus.err_count  = err_q;
  assign j              = j_q;
  assign k              = k_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: behavioural JK bank (with ignore-first and stuck
// stubs), table of single-try vectors, then retry/failure/reset/backpressure sequences.
module tb_jk_bank_driver;

  logic       clk;
  logic       clear_n;
  logic [3:0] q_fb, j, k;

  jk_bank_driver_if #(.WIDTH(4), .ERR_W(8)) bus ();

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(2), .ERR_W(8)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus),
    .q_fb    (q_fb),
    .j       (j),
    .k       (k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural JK bank
  logic [3:0] bank, bank_init, stuck_val;
  logic       bank_load, ignore_first, skipped, stuck_en;

  always @(posedge clk) begin
    if (bank_load) begin
      bank    <= bank_init;
      skipped <= 1'b0;
    end else if ((j | k) != 4'b0 && ignore_first && !skipped) begin
      skipped <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case ({j[i], k[i]})
          2'b01:   bank[i] <= 1'b0;
          2'b10:   bank[i] <= 1'b1;
          2'b11:   bank[i] <= ~bank[i];
          default: bank[i] <= bank[i];
        endcase
      end
    end
  end

  assign q_fb = stuck_en ? stuck_val : bank;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic load_bank(input logic [3:0] v);
    @(negedge clk);
    bank_init = v;
    bank_load = 1'b1;
    @(posedge clk);
    #1 bank_load = 1'b0;
  endtask

  // One full transaction; returns drive-cycle j/k, j|k one cycle later, response and latency
  task automatic do_txn(input logic [3:0] tgt, input logic tog,
                        output logic [3:0] dj, output logic [3:0] dk, output logic [3:0] jk_after,
                        output logic ok, output logic [2:0] tries, output int lat);
    @(negedge clk);
    bus.req_target = tgt;
    bus.req_toggle = tog;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    dj = j;
    dk = k;
    jk_after = 4'hx;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) jk_after = j | k;
    end
    chk("resp_timeout", 32'(bus.resp_valid), 32'd1);
    ok    = bus.resp_ok;
    tries = bus.resp_tries;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0] init;
    logic [3:0] target;
    logic       toggle;
    logic [3:0] exp_j;
    logic [3:0] exp_k;
  } vec_t;

  vec_t vecs [6];

  logic [3:0] dj, dk, jka;
  logic       ok;
  logic [2:0] tries;
  int         lat;
  int         seen;

  initial begin
    vecs[0] = '{4'b0000, 4'b1010, 1'b0, 4'b1010, 4'b0000};
    vecs[1] = '{4'b1100, 4'b0110, 1'b1, 4'b1010, 4'b1010};
    vecs[2] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b1111};
    vecs[3] = '{4'b0101, 4'b0101, 1'b1, 4'b0000, 4'b0000};
    vecs[4] = '{4'b0011, 4'b0101, 1'b0, 4'b0100, 4'b0010};
    vecs[5] = '{4'b1001, 4'b0110, 1'b1, 4'b1111, 4'b1111};

    clear_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_target = 4'b0;
    bus.req_toggle = 1'b0;
    bus.resp_ready = 1'b0;
    bank_init      = 4'b0;
    bank_load      = 1'b1;
    ignore_first   = 1'b0;
    stuck_en       = 1'b0;
    stuck_val      = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_err", 32'(bus.err_count), 32'd0);
    chk("rst_tries", 32'(bus.resp_tries), 32'd0);
    bank_load = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    #1 chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Single-try vectors against the real bank
    for (int v = 0; v < 6; v++) begin
      load_bank(vecs[v].init);
      do_txn(vecs[v].target, vecs[v].toggle, dj, dk, jka, ok, tries, lat);
      chk($sformatf("vec%0d_j", v), 32'(dj), 32'(vecs[v].exp_j));
      chk($sformatf("vec%0d_k", v), 32'(dk), 32'(vecs[v].exp_k));
      chk($sformatf("vec%0d_jk_released", v), 32'(jka), 32'd0);
      chk($sformatf("vec%0d_ok", v), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_tries", v), 32'(tries), 32'd1);
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_bank", v), 32'(bank), 32'(vecs[v].target));
    end

    // Bank ignores the first drive, follows the second
    ignore_first = 1'b1;
    load_bank(4'b0000);
    do_txn(4'b0001, 1'b0, dj, dk, jka, ok, tries, lat);
    chk("retry_ok", 32'(ok), 32'd1);
    chk("retry_tries", 32'(tries), 32'd2);
    chk("retry_lat", 32'(lat), 32'd4);
    chk("retry_bank", 32'(bank), 32'd1);
    ignore_first = 1'b0;

    // Stuck bank: three drives then failure
    stuck_en  = 1'b1;
    stuck_val = 4'b0000;
    do_txn(4'b1111, 1'b0, dj, dk, jka, ok, tries, lat);
    chk("fail_j", 32'(dj), 32'hf);
    chk("fail_ok", 32'(ok), 32'd0);
    chk("fail_tries", 32'(tries), 32'd3);
    chk("fail_lat", 32'(lat), 32'd6);
    chk("fail_err1", 32'(bus.err_count), 32'd1);
    for (int n = 0; n < 254; n++) do_txn(4'b1111, 1'b0, dj, dk, jka, ok, tries, lat);
    chk("fail_err255", 32'(bus.err_count), 32'hff);
    do_txn(4'b1111, 1'b0, dj, dk, jka, ok, tries, lat);
    chk("fail_err_sat", 32'(bus.err_count), 32'hff);
    stuck_en = 1'b0;

    // Reset during DRIVE: immediate clear, no response, next request fine
    load_bank(4'b0000);
    @(negedge clk);
    bus.req_target = 4'b0011;
    bus.req_toggle = 1'b0;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("midrst_drive_j", 32'(j), 32'h3);
    #2 clear_n = 1'b0;
    #1;
    chk("midrst_j", 32'(j), 32'd0);
    chk("midrst_k", 32'(k), 32'd0);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_err", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    #1 chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (bus.resp_valid) seen++;
    end
    chk("midrst_no_resp", 32'(seen), 32'd0);
    chk("midrst_bank_kept", 32'(bank), 32'd0);
    do_txn(4'b0011, 1'b0, dj, dk, jka, ok, tries, lat);
    chk("post_rst_ok", 32'(ok), 32'd1);
    chk("post_rst_tries", 32'(tries), 32'd1);
    chk("post_rst_bank", 32'(bank), 32'h3);

    // Backpressure with a held request, then handshake/request collision
    @(negedge clk);
    bus.req_target = 4'b0100;
    bus.req_toggle = 1'b1;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("bp_toggle_j", 32'(j), 32'h7);
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("bp_resp_seen", 32'(bus.resp_valid), 32'd1);
    bus.req_target = 4'b0000;
    bus.req_toggle = 1'b0;
    bus.req_valid  = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid !== 1'b1 || bus.resp_ok !== 1'b1 || bus.resp_tries !== 3'd1 || bus.req_ready !== 1'b0)
        seen++;
    end
    chk("bp_stable", 32'(seen), 32'd0);
    chk("bp_bank", 32'(bank), 32'h4);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    chk("coll_resp_dropped", 32'(bus.resp_valid), 32'd0);
    chk("coll_not_accepted", 32'(j | k), 32'd0);
    chk("coll_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("coll_accept_k", 32'(k), 32'h4);
    chk("coll_accept_j", 32'(j), 32'h0);
    chk("coll_busy", 32'(bus.req_ready), 32'd0);
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("coll_lat", 32'(lat), 32'd2);
    chk("coll_ok", 32'(bus.resp_ok), 32'd1);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    chk("coll_bank", 32'(bank), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
